// File: rtl/seven_segment_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_pkg
//  Description : Shared definitions for 7-segment display handling: pattern
//                type, blank pattern, hex glyph table (segment order A..G,
//                A in bit 6) and a pattern-to-hex decoder. The display
//                encoder uses the same table, so both directions agree.
//  Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    // Active-high segment pattern {A,B,C,D,E,F,G}
    typedef logic [6:0] seg_pattern_t;

    // Decoder result: legal glyph flag plus its hex value
    typedef struct packed {
        logic       legal;
        logic [3:0] value;
    } seg_decode_t;

    localparam seg_pattern_t SEG_BLANK = 7'h00;

    localparam seg_pattern_t SEG_GLYPH [0:15] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    // All table entries are distinct, so at most one index can match.
    function automatic seg_decode_t seg_decode(input seg_pattern_t pattern);
        seg_decode_t result;
        result = '0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_GLYPH[i]) begin
                result.legal = 1'b1;
                result.value = 4'(i);
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seven_segment_reader_stabilizer.sv
`default_nettype none
// ============================================================================
//  Module      : seven_segment_stabilizer
//  Description : Inverts the active-low segment lines, synchronizes them and
//                filters the result: a pattern commits once it has been seen
//                unchanged for the configured number of samples, exactly
//                once per stable episode.
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                segmentsN[6:0]  - raw active-low lines {A..G}
//                pattern[6:0]    - candidate pattern (valid when commit=1)
//                commit          - one-cycle strobe: pattern is committed now
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_stabilizer
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  seg_pattern_t segmentsN,
    output seg_pattern_t pattern,
    output logic         commit
);

    localparam logic [7:0] c_CNT_LAST = 8'(STABLE_CYCLES - 1);

    seg_pattern_t r_sync [SYNC_STAGES];
    seg_pattern_t r_cand;
    logic [7:0]   r_cnt;
    logic         r_done;    // current candidate already committed

    seg_pattern_t w_p;
    logic         w_commit;

    assign w_p = r_sync[SYNC_STAGES-1];

    // Commit is decoded from registered state so the top can register its
    // pulses on the same edge that completes the stability count.
    assign w_commit = (w_p == r_cand) && (r_cnt == c_CNT_LAST) && !r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_cand <= SEG_BLANK;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_sync[0] <= ~segmentsN;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end

            if (w_p != r_cand) begin
                r_cand <= w_p;
                r_cnt  <= '0;
                r_done <= 1'b0;
            end else if (r_cnt < c_CNT_LAST) begin
                r_cnt <= r_cnt + 8'd1;
            end else begin
                // Count holds; the flag blocks repeated commits
                r_done <= 1'b1;
            end
        end
    end

    assign pattern = r_cand;
    assign commit  = w_commit;

endmodule
`default_nettype wire

// File: rtl/seven_segment_reader.sv
`default_nettype none
// ============================================================================
//  Module      : seven_segment_reader
//  Description : Reads back a 7-segment display bus and reports the shown
//                hex digit with level (valid/blank) and pulse (update/error)
//                indications.
//  Ports       : clk, rst            - clock, asynchronous active-high reset
//                segmentA..segmentG  - active-low segment lines (0 = lit)
//                value[3:0]          - last committed hex digit
//                valid               - committed pattern is a legal glyph
//                blank               - committed pattern is all-off
//                update              - pulse: new digit or first lock
//                error               - pulse: stable illegal pattern
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_reader
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       segmentA,
    input  logic       segmentB,
    input  logic       segmentC,
    input  logic       segmentD,
    input  logic       segmentE,
    input  logic       segmentF,
    input  logic       segmentG,
    output logic [3:0] value,
    output logic       valid,
    output logic       blank,
    output logic       update,
    output logic       error
);

    localparam logic [1:0] c_ST_BLANK  = 2'd0;
    localparam logic [1:0] c_ST_LOCKED = 2'd1;
    localparam logic [1:0] c_ST_BAD    = 2'd2;

    seg_pattern_t w_pattern;
    logic         w_commit;
    seg_decode_t  w_decoded;

    logic [1:0]   r_state;
    logic [3:0]   r_value;
    logic         r_update;
    logic         r_error;

    logic [1:0]   w_nextState;
    logic [3:0]   w_nextValue;
    logic         w_nextUpdate;
    logic         w_nextError;

    seven_segment_stabilizer #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_stabilizer (
        .clk       (clk),
        .rst       (rst),
        .segmentsN ({segmentA, segmentB, segmentC, segmentD,
                     segmentE, segmentF, segmentG}),
        .pattern   (w_pattern),
        .commit    (w_commit)
    );

    assign w_decoded = seg_decode(w_pattern);

    // State register (pulses are registered here too)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_BLANK;
            r_value  <= 4'h0;
            r_update <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_value  <= w_nextValue;
            r_update <= w_nextUpdate;
            r_error  <= w_nextError;
        end
    end

    // Next state: only a commit strobe moves the committed state
    always_comb begin
        w_nextState  = r_state;
        w_nextValue  = r_value;
        w_nextUpdate = 1'b0;
        w_nextError  = 1'b0;
        if (w_commit) begin
            if (w_decoded.legal) begin
                w_nextState  = c_ST_LOCKED;
                w_nextValue  = w_decoded.value;
                // Re-locking after blank/bad reports even an unchanged digit
                w_nextUpdate = (r_state != c_ST_LOCKED) ||
                               (w_decoded.value != r_value);
            end else if (w_pattern == SEG_BLANK) begin
                w_nextState = c_ST_BLANK;
            end else begin
                w_nextState = c_ST_BAD;
                w_nextError = 1'b1;
            end
        end
    end

    // Outputs
    always_comb begin
        value  = r_value;
        valid  = (r_state == c_ST_LOCKED);
        blank  = (r_state == c_ST_BLANK);
        update = r_update;
        error  = r_error;
    end

endmodule
`default_nettype wire
